// File: rtl/post_hash_job_arbiter.sv
// Round-robin job arbiter for the post-hash PE scheduler input.
// A grant is held from job start to req_last; issue is throttled by an outstanding-beat credit count.
module post_hash_job_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int PAYLOAD_W       = 64,
    parameter int MAX_OUTSTANDING = 8,
    parameter int SRC_W           = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1,
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [CNT_W-1:0]             cfg_max_outstanding,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_last,
    input  logic [NUM_REQ*PAYLOAD_W-1:0] req_payload,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         out_valid,
    output logic                         out_last,
    output logic [SRC_W-1:0]             out_src,
    output logic [PAYLOAD_W-1:0]         out_payload,
    input  logic                         out_ready,
    input  logic                         ret_valid,
    output logic                         busy,
    output logic [CNT_W-1:0]             outstanding,
    output logic                         err_underflow
);

    typedef enum logic {IDLE, LOCKED} state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
    localparam int unsigned      NREQ_U  = NUM_REQ;

    state_t               state, state_nxt;
    logic [SRC_W-1:0]     rr_ptr, owner, win, win_plus1;
    logic                 any_valid;
    logic [CNT_W-1:0]     lim;
    logic                 credit_ok, slot_free, issue_ok, accept;
    logic                 owner_valid, owner_last;
    logic [PAYLOAD_W-1:0] owner_payload;

    always_comb begin
        if (cfg_max_outstanding == '0 || cfg_max_outstanding > MAX_CNT)
            lim = MAX_CNT;
        else
            lim = cfg_max_outstanding;
    end

    assign credit_ok = (outstanding < lim);
    assign slot_free = !out_valid || out_ready;
    assign issue_ok  = slot_free && credit_ok;

    // Priority scan starting at rr_ptr; the first hit in scan order wins.
    always_comb begin
        win       = '0;
        any_valid = 1'b0;
        for (int unsigned k = 0; k < NREQ_U; k++) begin
            for (int unsigned i = 0; i < NREQ_U; i++) begin
                if (!any_valid && req_valid[i] && i == (k + 32'(rr_ptr)) % NREQ_U) begin
                    any_valid = 1'b1;
                    win       = SRC_W'(i);
                end
            end
        end
    end

    assign win_plus1 = (win == SRC_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;

    always_comb begin
        owner_valid   = 1'b0;
        owner_last    = 1'b0;
        owner_payload = '0;
        for (int unsigned i = 0; i < NREQ_U; i++) begin
            if (owner == SRC_W'(i)) begin
                owner_valid   = req_valid[i];
                owner_last    = req_last[i];
                owner_payload = req_payload[i*PAYLOAD_W +: PAYLOAD_W];
            end
        end
    end

    assign accept = (state == LOCKED) && owner_valid && issue_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && any_valid) begin
                owner  <= win;
                rr_ptr <= win_plus1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_valid) state_nxt = LOCKED;
            LOCKED:  if (accept && owner_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        busy      = (state == LOCKED);
        if (state == LOCKED) begin
            for (int unsigned i = 0; i < NREQ_U; i++) begin
                if (owner == SRC_W'(i)) req_ready[i] = issue_ok;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_src     <= '0;
            out_payload <= '0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_last    <= owner_last;
            out_src     <= owner;
            out_payload <= owner_payload;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // A return with nothing in flight is flagged, not counted; accept+return nets to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding   <= '0;
            err_underflow <= 1'b0;
        end else begin
            case ({accept, ret_valid})
                2'b10: outstanding <= outstanding + 1'b1;
                2'b01: begin
                    if (outstanding == '0) err_underflow <= 1'b1;
                    else                   outstanding   <= outstanding - 1'b1;
                end
                default: outstanding <= outstanding;
            endcase
        end
    end

endmodule

// File: tb/tb_post_hash_job_arbiter.sv
// Scoreboard bench for post_hash_job_arbiter: jobs modelled per requester,
// accepted beats queued as expectations and popped as they leave the output register.
module tb_post_hash_job_arbiter;

    localparam int NUM_REQ = 4;
    localparam int PW      = 64;
    localparam int MO      = 8;
    localparam int SW      = 2;
    localparam int CW      = $clog2(MO + 1);

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [CW-1:0]           cfg;
    logic [NUM_REQ-1:0]      req_valid, req_last, req_ready;
    logic [NUM_REQ*PW-1:0]   req_payload;
    logic                    out_valid, out_last, out_ready, ret_valid, busy, err_underflow;
    logic [SW-1:0]           out_src;
    logic [PW-1:0]           out_payload;
    logic [CW-1:0]           outstanding;

    post_hash_job_arbiter #(
        .NUM_REQ(NUM_REQ), .PAYLOAD_W(PW), .MAX_OUTSTANDING(MO), .SRC_W(SW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_max_outstanding(cfg),
        .req_valid(req_valid), .req_last(req_last), .req_payload(req_payload),
        .req_ready(req_ready), .out_valid(out_valid), .out_last(out_last),
        .out_src(out_src), .out_payload(out_payload), .out_ready(out_ready),
        .ret_valid(ret_valid), .busy(busy), .outstanding(outstanding),
        .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [SW-1:0] src;
        logic          last;
        logic [PW-1:0] payload;
    } beat_t;

    beat_t sb[$];
    int    grant_log[$];
    int    n_cmp = 0, n_err = 0, popped = 0;
    int    job_len[NUM_REQ], jobs_left[NUM_REQ], beat_idx[NUM_REQ], seq[NUM_REQ];

    function automatic logic [PW-1:0] mk_payload(input int i, input int s);
        return {8'(i + 8'hA0), 24'(s), 32'hDEAD_0000 ^ 32'(s * 7 + i * 131)};
    endfunction

    task automatic drive_reqs();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i]              = (jobs_left[i] > 0);
            req_last[i]               = (beat_idx[i] == job_len[i] - 1);
            req_payload[i*PW +: PW]   = mk_payload(i, seq[i]);
        end
    endtask

    always @(posedge clk) begin
        #1;
        drive_reqs();
    end

    // Pop the beat leaving the register first, then queue the beat entering it.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_unexpected: got src=%0d last=%0d payload=%h, required no beat",
                             out_src, out_last, out_payload);
                end else begin
                    beat_t exp_b;
                    exp_b = sb.pop_front();
                    popped++;
                    if ({out_src, out_last, out_payload} !== exp_b) begin
                        n_err++;
                        $display("FAIL sb_beat: got src=%0d last=%0d payload=%h, required src=%0d last=%0d payload=%h",
                                 out_src, out_last, out_payload, exp_b.src, exp_b.last, exp_b.payload);
                    end
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    beat_t nb;
                    nb.src     = SW'(i);
                    nb.last    = (beat_idx[i] == job_len[i] - 1);
                    nb.payload = mk_payload(i, seq[i]);
                    sb.push_back(nb);
                    grant_log.push_back(i);
                    seq[i]++;
                    if (nb.last) begin
                        beat_idx[i] = 0;
                        jobs_left[i]--;
                    end else begin
                        beat_idx[i]++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_model();
        for (int i = 0; i < NUM_REQ; i++) begin
            job_len[i] = 1; jobs_left[i] = 0; beat_idx[i] = 0;
        end
        sb.delete();
        grant_log.delete();
        popped = 0;
        drive_reqs();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; ret_valid = 1'b0; out_ready = 1'b1; cfg = '0;
        clear_model();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
    endtask

    task automatic ret_pulses(input int n);
        @(posedge clk);
        #2 ret_valid = 1'b1;
        repeat (n) tick();
        ret_valid = 1'b0;
    endtask

    task automatic wait_log(input int n, input int bound, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < bound; c++) begin
            @(negedge clk);
            #1;
            if (grant_log.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < NUM_REQ; i++) seq[i] = 0;
        rst_n = 1'b0; ret_valid = 1'b0; out_ready = 1'b1; cfg = '0;
        clear_model();
        #3;
        n_cmp++;
        if ({out_valid, out_last, out_src, out_payload, req_ready, busy, outstanding, err_underflow} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got valid=%0d last=%0d src=%0d pay=%h rdy=%b busy=%0d outst=%0d err=%0d, required all 0",
                     out_valid, out_last, out_src, out_payload, req_ready, busy, outstanding, err_underflow);
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({out_valid, req_ready, busy, outstanding, err_underflow} !== '0) begin
            n_err++;
            $display("FAIL reset_idle: got valid=%0d rdy=%b busy=%0d outst=%0d err=%0d, required all 0",
                     out_valid, req_ready, busy, outstanding, err_underflow);
        end
        tick();
    endtask

    task automatic test_single_job();
        job_len[0] = 3; jobs_left[0] = 1; beat_idx[0] = 0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({busy, req_ready} !== 5'b0_0000) begin
            n_err++;
            $display("FAIL t1_grant_cycle: got busy=%0d rdy=%b, required busy=0 rdy=0000", busy, req_ready);
        end
        @(negedge clk);
        n_cmp++;
        if ({busy, req_ready, out_valid} !== 6'b1_0001_0) begin
            n_err++;
            $display("FAIL t1_bubble: got busy=%0d rdy=%b out_valid=%0d, required 1 0001 0", busy, req_ready, out_valid);
        end
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            n_cmp++;
            if ({out_valid, out_src, out_last} !== 4'b1_00_0) begin
                n_err++;
                $display("FAIL t1_beat%0d: got valid=%0d src=%0d last=%0d, required 1 0 0", b, out_valid, out_src, out_last);
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({out_valid, out_src, out_last, busy, outstanding} !== {1'b1, 2'd0, 1'b1, 1'b0, 4'd3}) begin
            n_err++;
            $display("FAIL t1_last_beat: got valid=%0d src=%0d last=%0d busy=%0d outst=%0d, required 1 0 1 0 3",
                     out_valid, out_src, out_last, busy, outstanding);
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || popped != 3 || sb.size() != 0) begin
            n_err++;
            $display("FAIL t1_drain: got valid=%0d popped=%0d queued=%0d, required 0 3 0", out_valid, popped, sb.size());
        end
        ret_pulses(3);
        @(negedge clk);
        n_cmp++;
        if (outstanding !== '0) begin
            n_err++;
            $display("FAIL t1_credit_return: got outst=%0d, required 0", outstanding);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        int exp_order[4] = '{1, 3, 1, 3};
        apply_reset();
        job_len[1] = 1; jobs_left[1] = 2;
        job_len[3] = 1; jobs_left[3] = 2;
        wait_log(4, 40, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL t2_timeout: got %0d grants, required 4", grant_log.size());
        end
        for (int g = 0; g < 4; g++) begin
            n_cmp++;
            if (grant_log.size() <= g || grant_log[g] != exp_order[g]) begin
                n_err++;
                $display("FAIL t2_order%0d: got %0d, required %0d", g,
                         (grant_log.size() > g) ? grant_log[g] : -1, exp_order[g]);
            end
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (popped != 4 || sb.size() != 0 || outstanding !== 4'd4) begin
            n_err++;
            $display("FAIL t2_drain: got popped=%0d queued=%0d outst=%0d, required 4 0 4", popped, sb.size(), outstanding);
        end
        ret_pulses(4);
    endtask

    task automatic test_credit_limit();
        bit ok;
        cfg = 4'd2; popped = 0; grant_log.delete();
        job_len[2] = 5; jobs_left[2] = 1; beat_idx[2] = 0;
        wait_log(2, 20, ok);
        repeat (4) @(negedge clk);
        n_cmp++;
        if (!ok || grant_log.size() != 2 || req_ready !== 4'b0000 || outstanding !== 4'd2) begin
            n_err++;
            $display("FAIL t3_limit_stall: got accepts=%0d rdy=%b outst=%0d, required 2 0000 2",
                     grant_log.size(), req_ready, outstanding);
        end
        ret_pulses(1);
        repeat (4) @(negedge clk);
        n_cmp++;
        if (grant_log.size() != 3 || outstanding !== 4'd2 || req_ready !== 4'b0000) begin
            n_err++;
            $display("FAIL t3_one_release: got accepts=%0d outst=%0d rdy=%b, required 3 2 0000",
                     grant_log.size(), outstanding, req_ready);
        end
        cfg = '0;
        wait_log(5, 20, ok);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (!ok || popped != 5 || sb.size() != 0 || outstanding !== 4'd4) begin
            n_err++;
            $display("FAIL t3_finish: got popped=%0d queued=%0d outst=%0d, required 5 0 4", popped, sb.size(), outstanding);
        end
        ret_pulses(4);
    endtask

    task automatic test_backpressure();
        bit seen = 1'b0;
        popped = 0; grant_log.delete();
        job_len[0] = 3; jobs_left[0] = 1; beat_idx[0] = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            seen = out_valid;
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL t4_timeout: got no out_valid, required a beat");
        end
        @(posedge clk);
        #2 out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++;
            if (sb.size() != 1 || {out_valid, out_src, out_last, out_payload, req_ready} !==
                {1'b1, sb[0].src, sb[0].last, sb[0].payload, 4'b0000}) begin
                n_err++;
                $display("FAIL t4_hold%0d: got valid=%0d src=%0d last=%0d pay=%h rdy=%b queued=%0d, required held beat, rdy 0000, queued 1",
                         c, out_valid, out_src, out_last, out_payload, req_ready, sb.size());
            end
        end
        @(posedge clk);
        #2 out_ready = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (popped != 3 || sb.size() != 0 || outstanding !== 4'd3) begin
            n_err++;
            $display("FAIL t4_no_loss: got popped=%0d queued=%0d outst=%0d, required 3 0 3", popped, sb.size(), outstanding);
        end
        ret_pulses(3);
    endtask

    task automatic test_credit_edges();
        bit seen = 1'b0;
        grant_log.delete();
        job_len[1] = 4; jobs_left[1] = 1; beat_idx[1] = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            seen = (outstanding == 4'd3);
        end
        n_cmp++;
        if (!seen || req_ready !== 4'b0010) begin
            n_err++;
            $display("FAIL t5_setup: got outst=%0d rdy=%b, required 3 0010", outstanding, req_ready);
        end
        ret_valid = 1'b1;
        @(posedge clk);
        #2 ret_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (outstanding !== 4'd3 || grant_log.size() != 4) begin
            n_err++;
            $display("FAIL t5_same_cycle: got outst=%0d accepts=%0d, required 3 4", outstanding, grant_log.size());
        end
        repeat (2) @(negedge clk);
        ret_pulses(3);
        @(negedge clk);
        n_cmp++;
        if ({err_underflow, outstanding} !== 5'b0_0000) begin
            n_err++;
            $display("FAIL t5_drained: got err=%0d outst=%0d, required 0 0", err_underflow, outstanding);
        end
        ret_pulses(1);
        @(negedge clk);
        n_cmp++;
        if ({err_underflow, outstanding} !== 5'b1_0000) begin
            n_err++;
            $display("FAIL t5_underflow: got err=%0d outst=%0d, required 1 0", err_underflow, outstanding);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (err_underflow !== 1'b1) begin
            n_err++;
            $display("FAIL t5_sticky: got err=%0d, required 1", err_underflow);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        grant_log.delete();
        job_len[2] = 6; jobs_left[2] = 1; beat_idx[2] = 0;
        wait_log(2, 20, ok);
        n_cmp++;
        if (!ok || busy !== 1'b1 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL t6_mid_job: got busy=%0d valid=%0d, required 1 1", busy, out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, out_last, out_src, out_payload, req_ready, busy, outstanding, err_underflow} !== '0) begin
            n_err++;
            $display("FAIL t6_async_clear: got valid=%0d last=%0d src=%0d pay=%h rdy=%b busy=%0d outst=%0d err=%0d, required all 0",
                     out_valid, out_last, out_src, out_payload, req_ready, busy, outstanding, err_underflow);
        end
        clear_model();
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        job_len[3] = 1; jobs_left[3] = 1;
        job_len[1] = 1; jobs_left[1] = 1;
        wait_log(2, 30, ok);
        n_cmp++;
        if (!ok || grant_log[0] != 1 || grant_log[1] != 3) begin
            n_err++;
            $display("FAIL t6_first_grant: got %0d then %0d, required 1 then 3",
                     (grant_log.size() > 0) ? grant_log[0] : -1, (grant_log.size() > 1) ? grant_log[1] : -1);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0 || outstanding !== 4'd2) begin
            n_err++;
            $display("FAIL t6_drain: got queued=%0d outst=%0d, required 0 2", sb.size(), outstanding);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_job();
        test_round_robin();
        test_credit_limit();
        test_backpressure();
        test_credit_edges();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
